// File: rtl/cceip_inbound_adapter_if.sv
// Stream bundle between the memory-read side and the CCEIP engine ingress.
// master is the adapter's view; slave is the environment's (source and sink) view.
interface cceip_inbound_adapter_if #(
    parameter int DATA_W = 64
);
    logic                  mm_s_axis_tvalid;
    logic [DATA_W-1:0]     mm_s_axis_tdata;
    logic                  mm_s_axis_tready;
    logic                  cceip_m_axis_tvalid;
    logic [DATA_W-1:0]     cceip_m_axis_tdata;
    logic [DATA_W/8-1:0]   cceip_m_axis_tstrb;
    logic                  cceip_m_axis_tlast;
    logic                  cceip_m_axis_tready;

    modport master (
        input  mm_s_axis_tvalid, mm_s_axis_tdata, cceip_m_axis_tready,
        output mm_s_axis_tready, cceip_m_axis_tvalid, cceip_m_axis_tdata,
               cceip_m_axis_tstrb, cceip_m_axis_tlast
    );

    modport slave (
        output mm_s_axis_tvalid, mm_s_axis_tdata, cceip_m_axis_tready,
        input  mm_s_axis_tready, cceip_m_axis_tvalid, cceip_m_axis_tdata,
               cceip_m_axis_tstrb, cceip_m_axis_tlast
    );
endinterface

// File: rtl/cceip_inbound_adapter.sv
// Passes exactly input_data_size bytes from the memory stream to the engine,
// adding strobes/tlast on the final beat and pulsing done afterwards.
module cceip_inbound_adapter #(
    parameter int DATA_W = 64,
    parameter int SIZE_W = 64
) (
    input  logic                 ap_clk,
    input  logic                 areset,
    input  logic                 inbound_start,
    input  logic [SIZE_W-1:0]    input_data_size,
    cceip_inbound_adapter_if.master axis,
    output logic                 inbound_busy,
    output logic                 inbound_done
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t              state, state_n;
    logic [SIZE_W-1:0]   remaining;
    logic                start_q;
    logic                start_edge;
    logic                last;
    logic                beat;
    logic [STRB_W-1:0]   strb;

    logic                tvalid, tready, tlast, busy, done;
    logic [DATA_W-1:0]   tdata;
    logic [STRB_W-1:0]   tstrb;

    assign start_edge = inbound_start & ~start_q;
    assign last       = (remaining <= SIZE_W'(STRB_W));
    assign beat       = (state == XFER) & axis.mm_s_axis_tvalid & axis.cceip_m_axis_tready;
    // Below a full beat, remaining is < 8 so its low three bits are the byte count.
    assign strb       = (remaining >= SIZE_W'(STRB_W)) ? {STRB_W{1'b1}}
                      : ((STRB_W'(1) << remaining[2:0]) - STRB_W'(1));

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state     <= IDLE;
            remaining <= '0;
            start_q   <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= inbound_start;
            if (state == IDLE && start_edge) begin
                remaining <= input_data_size;
            end else if (beat) begin
                remaining <= (remaining > SIZE_W'(STRB_W)) ? remaining - SIZE_W'(STRB_W) : '0;
            end
        end
    end

    always_comb begin
        state_n = state;
        tvalid  = 1'b0;
        tready  = 1'b0;
        tdata   = '0;
        tstrb   = '0;
        tlast   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_n = (input_data_size != '0) ? XFER : DONE;
                end
            end
            XFER: begin
                busy   = 1'b1;
                tready = axis.cceip_m_axis_tready;
                tvalid = axis.mm_s_axis_tvalid;
                if (axis.mm_s_axis_tvalid) begin
                    tdata = axis.mm_s_axis_tdata;
                    tstrb = strb;
                    tlast = last;
                end
                if (beat && last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Outputs are forced quiet while reset is held, even if state is still XFER.
        if (areset) begin
            tvalid = 1'b0;
            tready = 1'b0;
            tdata  = '0;
            tstrb  = '0;
            tlast  = 1'b0;
            busy   = 1'b0;
            done   = 1'b0;
        end
    end

    assign axis.cceip_m_axis_tvalid = tvalid;
    assign axis.mm_s_axis_tready    = tready;
    assign axis.cceip_m_axis_tdata  = tdata;
    assign axis.cceip_m_axis_tstrb  = tstrb;
    assign axis.cceip_m_axis_tlast  = tlast;
    assign inbound_busy             = busy;
    assign inbound_done             = done;
endmodule

// File: tb/tb_cceip_inbound_adapter.sv
// Scoreboard bench for cceip_inbound_adapter: expected beats are queued at start
// and matched against beats observed on the engine stream.
module tb_cceip_inbound_adapter;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_t;

    logic        ap_clk = 1'b0;
    logic        areset = 1'b1;
    logic        inbound_start = 1'b0;
    logic [63:0] input_data_size = '0;
    logic        inbound_busy;
    logic        inbound_done;
    logic [63:0] src_data = 64'd1;

    int checks = 0;
    int errors = 0;

    beat_t exp_q[$];
    beat_t obs_q[$];

    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int tv_cnt = 0;
    int last_cyc = -1;
    int done_cyc = -1;
    int start_cyc = 0;

    cceip_inbound_adapter_if #(.DATA_W(64)) ifc ();

    assign ifc.mm_s_axis_tdata = src_data;

    cceip_inbound_adapter #(.DATA_W(64), .SIZE_W(64)) dut (
        .ap_clk          (ap_clk),
        .areset          (areset),
        .inbound_start   (inbound_start),
        .input_data_size (input_data_size),
        .axis            (ifc.master),
        .inbound_busy    (inbound_busy),
        .inbound_done    (inbound_done)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    always @(negedge ap_clk) begin
        if (!areset) begin
            if (ifc.cceip_m_axis_tvalid && ifc.cceip_m_axis_tready) begin
                obs_q.push_back('{ifc.cceip_m_axis_tdata, ifc.cceip_m_axis_tstrb, ifc.cceip_m_axis_tlast});
                if (ifc.cceip_m_axis_tlast) last_cyc = cyc;
            end
            if (ifc.mm_s_axis_tvalid && ifc.mm_s_axis_tready) hs_cnt++;
            if (inbound_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (inbound_busy) busy_cnt++;
            if (ifc.cceip_m_axis_tvalid) tv_cnt++;
        end
    end

    // Reference model: ceil(size/8) beats, consecutive data, low-byte strobes on a partial tail.
    task automatic push_expected(input longint size, input logic [63:0] base);
        longint rem = size;
        logic [63:0] d = base;
        while (rem > 0) begin
            beat_t b;
            b.data = d;
            b.strb = (rem >= 8) ? 8'hFF : 8'((16'd1 << rem) - 16'd1);
            b.last = (rem <= 8);
            exp_q.push_back(b);
            rem = (rem > 8) ? rem - 8 : 0;
            d = d + 1;
        end
    endtask

    task automatic start_xfer(input logic [63:0] size);
        @(posedge ap_clk); #1;
        inbound_start = 1'b0;
        @(posedge ap_clk); #1;
        inbound_start   = 1'b1;
        input_data_size = size;
        start_cyc       = cyc;
    endtask

    // Acts as the upstream source: advances data after each accepted beat.
    task automatic run_stream(input bit toggle, input int budget, input bit poke, output bit got_done);
        bit hs;
        got_done = 1'b0;
        for (int c = 0; c < budget && !got_done; c++) begin
            @(negedge ap_clk);
            hs = ifc.mm_s_axis_tvalid && ifc.mm_s_axis_tready;
            if (ifc.cceip_m_axis_tvalid) begin
                checks++;
                if (ifc.cceip_m_axis_tdata !== src_data) begin
                    errors++;
                    $display("FAIL passthru_data: got %h want %h", ifc.cceip_m_axis_tdata, src_data);
                end
            end
            if (inbound_done) got_done = 1'b1;
            @(posedge ap_clk); #1;
            if (hs) src_data = src_data + 1;
            if (toggle) ifc.cceip_m_axis_tready = ~ifc.cceip_m_axis_tready;
            if (poke && c == 0) inbound_start = 1'b0;
            if (poke && c == 1) begin
                inbound_start   = 1'b1;
                input_data_size = 64'd64;
            end
        end
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        ifc.mm_s_axis_tvalid    = 1'b1;
        ifc.cceip_m_axis_tready = 1'b1;
        repeat (20) @(posedge ap_clk);
        @(negedge ap_clk);
        checks++;
        if ({ifc.cceip_m_axis_tvalid, ifc.mm_s_axis_tready, ifc.cceip_m_axis_tlast,
             ifc.cceip_m_axis_tstrb, inbound_busy, inbound_done} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs during reset");
        end
        @(posedge ap_clk); #1;
        areset = 1'b0;
        @(negedge ap_clk);
        checks++;
        if ({ifc.cceip_m_axis_tvalid, ifc.mm_s_axis_tready, inbound_busy, inbound_done} !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got nonzero outputs after reset");
        end
    endtask

    task automatic test_single_partial();
        bit d;
        int d0 = done_cnt, h0;
        src_data = 64'd1;
        push_expected(6, 64'd1);
        start_xfer(64'd6);
        run_stream(1'b0, 20, 1'b0, d);
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            beat_t e = exp_q.pop_front();
            beat_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_beat: got %h/%h/%b want %h/%h/%b", o.data, o.strb, o.last, e.data, e.strb, e.last);
            end
        end
        exp_q.delete(); obs_q.delete();
        h0 = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            checks++;
            if (ifc.mm_s_axis_tready !== 1'b0 || inbound_busy !== 1'b0) begin
                errors++;
                $display("FAIL held_start_idle: got tready %b busy %b want 0 0", ifc.mm_s_axis_tready, inbound_busy);
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || hs_cnt != h0) begin
            errors++;
            $display("FAIL single_done: got done %0d extra_hs %0d want 1 0", done_cnt - d0, hs_cnt - h0);
        end
    endtask

    task automatic test_back_to_back();
        bit d;
        src_data = 64'd1;
        push_expected(24, 64'd1);
        start_xfer(64'd24);
        run_stream(1'b0, 30, 1'b0, d);
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            beat_t e = exp_q.pop_front();
            beat_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_beat: got %h/%h/%b want %h/%h/%b", o.data, o.strb, o.last, e.data, e.strb, e.last);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (done_cyc != last_cyc + 1) begin
            errors++;
            $display("FAIL b2b_done_timing: got done cycle %0d want %0d", done_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_backpressure();
        bit d;
        int h0 = hs_cnt;
        src_data = 64'd1;
        push_expected(20, 64'd1);
        start_xfer(64'd20);
        run_stream(1'b1, 40, 1'b0, d);
        ifc.cceip_m_axis_tready = 1'b1;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            beat_t e = exp_q.pop_front();
            beat_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bp_beat: got %h/%h/%b want %h/%h/%b", o.data, o.strb, o.last, e.data, e.strb, e.last);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (hs_cnt - h0 != 3) begin
            errors++;
            $display("FAIL bp_handshakes: got %0d want 3", hs_cnt - h0);
        end
    endtask

    task automatic test_zero_size();
        bit d;
        int t0 = tv_cnt, b0 = busy_cnt, d0 = done_cnt;
        start_xfer(64'd0);
        run_stream(1'b0, 10, 1'b0, d);
        repeat (3) @(posedge ap_clk);
        checks++;
        if (tv_cnt != t0 || busy_cnt - b0 != 1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL zero_size: got tvalid %0d busy %0d done %0d want 0 1 1", tv_cnt - t0, busy_cnt - b0, done_cnt - d0);
        end
        checks++;
        if (done_cyc != start_cyc + 1) begin
            errors++;
            $display("FAIL zero_done_timing: got cycle %0d want %0d", done_cyc, start_cyc + 1);
        end
    endtask

    task automatic test_reset_mid();
        bit d, seen;
        int d0 = done_cnt, h0 = hs_cnt;
        src_data = 64'd1;
        exp_q.push_back('{64'd1, 8'hFF, 1'b0});
        start_xfer(64'd32);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ap_clk);
            if (ifc.mm_s_axis_tvalid && ifc.mm_s_axis_tready) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_first_beat: got no handshake within 20 cycles");
        end
        @(posedge ap_clk); #1;
        src_data      = src_data + 1;
        areset        = 1'b1;
        inbound_start = 1'b0;
        @(negedge ap_clk);
        checks++;
        if ({ifc.cceip_m_axis_tvalid, ifc.mm_s_axis_tready, ifc.cceip_m_axis_tlast,
             ifc.cceip_m_axis_tstrb, inbound_busy, inbound_done} !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got nonzero outputs under reset");
        end
        @(posedge ap_clk); #1;
        areset = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (inbound_busy !== 1'b0 || ifc.cceip_m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_reset: got busy %b tvalid %b want 0 0", inbound_busy, ifc.cceip_m_axis_tvalid);
        end
        checks++;
        if (done_cnt != d0 || hs_cnt - h0 != 1) begin
            errors++;
            $display("FAIL mid_abandon: got done %0d hs %0d want 0 1", done_cnt - d0, hs_cnt - h0);
        end
        src_data = 64'd5;
        push_expected(8, 64'd5);
        start_xfer(64'd8);
        run_stream(1'b0, 20, 1'b0, d);
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL mid_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            beat_t e = exp_q.pop_front();
            beat_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mid_beat: got %h/%h/%b want %h/%h/%b", o.data, o.strb, o.last, e.data, e.strb, e.last);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_start_while_busy();
        bit d;
        int d0 = done_cnt, h0 = hs_cnt;
        src_data = 64'd9;
        push_expected(16, 64'd9);
        start_xfer(64'd16);
        run_stream(1'b0, 20, 1'b1, d);
        repeat (6) @(posedge ap_clk);
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL busy_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            beat_t e = exp_q.pop_front();
            beat_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL busy_beat: got %h/%h/%b want %h/%h/%b", o.data, o.strb, o.last, e.data, e.strb, e.last);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (done_cnt - d0 != 1 || hs_cnt - h0 != 2) begin
            errors++;
            $display("FAIL busy_ignore: got done %0d hs %0d want 1 2", done_cnt - d0, hs_cnt - h0);
        end
    endtask

    initial begin
        ifc.mm_s_axis_tvalid    = 1'b1;
        ifc.cceip_m_axis_tready = 1'b1;
        test_reset();
        test_single_partial();
        test_back_to_back();
        test_backpressure();
        test_zero_size();
        test_reset_mid();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cceip_inbound_adapter.md
Name: cceip_inbound_adapter

Overview:
- Inbound framing stage between the memory-read AXI-Stream (mm_s_axis) and the CCEIP engine's ingress AXI-Stream (cceip_m_axis).
- On a start request it passes exactly input_data_size bytes, as 64-bit beats, from the memory stream to the engine.
- It generates the byte strobes and tlast for the final beat, then reports completion.
- Beats beyond the requested size are never accepted from the memory side.

Parameters:
- DATA_W, 64, stream data width in bits; fixed at 64, the only supported value.
- SIZE_W, 64, width of the byte-count input.

Ports:
- ap_clk  in  1  single clock; all logic rising-edge.
- areset  in  1  synchronous, active-high reset.
- inbound_start  in  1  start request; rising edge (0→1 between consecutive cycles) starts a transfer.
- input_data_size  in  SIZE_W  transfer length in bytes; sampled on the start edge.
- mm_s_axis_tvalid  in  1  memory stream valid.
- mm_s_axis_tdata  in  64  memory stream data, little-endian bytes.
- mm_s_axis_tready  out  1  memory stream ready.
- cceip_m_axis_tvalid  out  1  engine stream valid.
- cceip_m_axis_tdata  out  64  engine stream data.
- cceip_m_axis_tstrb  out  8  byte strobes; bit i qualifies byte i (bits 8i+7:8i).
- cceip_m_axis_tlast  out  1  final beat of the transfer.
- cceip_m_axis_tready  in  1  engine ready.
- inbound_busy  out  1  transfer in progress.
- inbound_done  out  1  one-cycle pulse when a transfer completes.

Behaviour:
- State machine: IDLE, XFER, DONE.
- Reset state:
  - state = IDLE; remaining = 0; start_q = 0.
  - All outputs 0 during and after reset: tvalid, tready, tlast, tstrb, busy, done.
  - Reset mid-transfer abandons the transfer immediately; no done pulse is generated.
- Start detection:
  - start_q is a register of inbound_start.
  - start_edge = inbound_start & ~start_q.
  - start_q updates every cycle, including while busy.
  - A level held high starts exactly one transfer.
- IDLE:
  - On start_edge, remaining <= input_data_size.
  - Next state: XFER if size ≠ 0, else DONE.
  - Start edges are ignored in XFER and DONE.
- XFER:
  - The path is combinational pass-through with no added latency.
  - cceip_m_axis_tvalid = mm_s_axis_tvalid.
  - mm_s_axis_tready = cceip_m_axis_tready.
  - cceip_m_axis_tdata = mm_s_axis_tdata.
  - A beat transfers when mm_s_axis_tvalid & cceip_m_axis_tready.
  - last = (remaining ≤ 8); cceip_m_axis_tlast = last.
  - tstrb = 8'hFF when remaining ≥ 8, else (1<<remaining)−1 (e.g. remaining 6 → 8'h3F).
  - On each beat, remaining <= remaining − 8, saturating at 0.
  - On the last beat, next state is DONE.
  - tstrb, tlast and tdata are only meaningful while tvalid = 1, and are driven 0 when tvalid = 0.
- DONE:
  - inbound_done = 1 for exactly one cycle, then IDLE.
- inbound_busy = 1 in XFER and DONE.
- Outside XFER: mm_s_axis_tready = 0 and cceip_m_axis_tvalid = 0, so upstream data is held, not dropped.
- Beat count = ceil(size/8); a trailing partial beat carries low-order bytes only.
- Backpressure: tvalid/tdata follow the upstream source; the adapter adds no buffering, so AXI hold rules are met when the source obeys them.
- A start edge in the same cycle as the DONE pulse is ignored. A new transfer needs a fresh rising edge after return to IDLE.

Test Plan:
- Reset 20 cycles, then inbound_start=1 held, size=6, upstream always valid with data 1, sink always ready → one beat, data 1, tstrb 8'h3F, tlast 1; done pulses once; mm_s_axis_tready then stays 0 despite start still high.
- size=24, continuous valid/ready, data 1,2,3 → three beats with tstrb FF,FF,FF; tlast on beat 3 only; done one cycle after beat 3.
- size=20, sink ready toggling 1,0,1,0… → data unchanged while stalled; beats FF,FF,0F; tlast on third accepted beat; exactly 3 upstream handshakes.
- size=0 start → no tvalid ever asserted; busy high one cycle; done pulse one cycle after start edge.
- Assert areset mid-transfer (after 1 of 4 beats) → all outputs 0 next cycle; no done; a new start edge with size=8 then yields one beat, tstrb FF, tlast 1.
- Start pulse while busy (size=16 in progress, second edge with size=64) → ignored; exactly 2 beats; single done.
